seq_to_sim_frame_reg: RTL and testbench



---
 rtl/seq_to_sim_frame_reg.sv | 153 +++++++++++++++
 tb/tb_seq_to_sim_frame_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_to_sim_frame_reg.sv
// Multi-lane framed sequential-to-simultaneous register with a valid/ready holding stage.
// Optional short-frame flush is enabled by defining SEQ_TO_SIM_FRAME_FLUSH_EN.
module seq_to_sim_frame_reg #(
   parameter int DIRECTION    = 1,
   parameter int SHIFT_LEN    = 8,
   parameter int BIT_WIDTH    = 2,
   parameter int LANES        = 1,
   parameter int CLK_DISTANCE = 1
) (
   input  logic                           clk,
   input  logic                           in_ctr_Arst,
   input  logic                           in_ctr_Srst,
   input  logic                           in_ctr_en,
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
   input  logic                           in_ctr_flush,
`endif
   output logic                           in_ready,
   input  logic [BIT_WIDTH*LANES-1:0]     in,
   output logic [BIT_WIDTH*SHIFT_LEN-1:0] out,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_partial
);

   localparam int CD     = (CLK_DISTANCE < 1) ? 1 : CLK_DISTANCE;
   localparam int BEATS  = (SHIFT_LEN / LANES < 1) ? 1 : SHIFT_LEN / LANES;
   localparam int FILL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DEC_W  = (CD > 1) ? $clog2(CD) : 1;
   localparam int FW     = BIT_WIDTH * SHIFT_LEN;

   generate
      if (SHIFT_LEN % LANES != 0) begin : g_len_check
         $error("seq_to_sim_frame_reg: SHIFT_LEN must be a multiple of LANES");
      end
   endgenerate

   // Arrival position p (0 = oldest word of the frame) to output slot.
   function automatic int slot_of(input int p);
      return (DIRECTION > 0) ? (SHIFT_LEN - 1 - p) : p;
   endfunction

   logic [FW-1:0]     r_coll;
   logic [FILL_W-1:0] r_fill;
   logic [DEC_W-1:0]  r_dec;
   logic [FW-1:0]     r_out;
   logic              r_valid;
   logic              r_partial;
   logic              r_pend;

   logic [FW-1:0]     w_coll_next;
   logic              w_dec_hit;
   logic              w_last;
   logic              w_hold_free;
   logic              w_beat;
   logic              w_sample;
   logic              w_complete;
   logic              w_flush_req;
   logic              w_has_data;
   logic              w_flush_go;
   logic              w_flush_hold;
   logic              w_load;

`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
   assign w_flush_req = in_ctr_flush | r_pend;
`else
   assign w_flush_req = 1'b0;
`endif

   assign w_dec_hit   = (r_dec == DEC_W'(CD - 1));
   assign w_last      = (r_fill == FILL_W'(BEATS - 1));
   assign w_hold_free = !r_valid | out_ready;
   // A completing beat is the only one that needs the holding register free.
   assign in_ready    = !(w_dec_hit & w_last & r_valid & !out_ready) & !r_pend;
   assign w_beat      = in_ctr_en & in_ready;
   assign w_sample    = w_beat & w_dec_hit;
   assign w_complete  = w_sample & w_last;
   assign w_has_data  = w_sample | (r_fill != {FILL_W{1'b0}});
   assign w_flush_go  = w_flush_req & !w_complete & w_has_data & w_hold_free;
   assign w_flush_hold = w_flush_req & !w_complete & w_has_data & !w_hold_free;
   assign w_load      = w_complete | w_flush_go;

   assign out         = r_out;
   assign out_valid   = r_valid;
   assign out_partial = r_partial;

   // Collector image with the current sampled beat merged into its slots.
   always_comb begin
      w_coll_next = r_coll;
      for (int b = 0; b < BEATS; b++) begin
         for (int k = 0; k < LANES; k++) begin
            w_coll_next[slot_of(b*LANES + k)*BIT_WIDTH +: BIT_WIDTH] =
               (w_sample && (r_fill == FILL_W'(b))) ? in[k*BIT_WIDTH +: BIT_WIDTH]
                                                   : r_coll[slot_of(b*LANES + k)*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   // Collector, fill counter and decimation counter.
   always_ff @(posedge clk or posedge in_ctr_Arst) begin
      if (in_ctr_Arst) begin
         r_coll <= {FW{1'b0}};
         r_fill <= {FILL_W{1'b0}};
         r_dec  <= {DEC_W{1'b0}};
         r_pend <= 1'b0;
      end else if (in_ctr_Srst) begin
         r_coll <= {FW{1'b0}};
         r_fill <= {FILL_W{1'b0}};
         r_dec  <= {DEC_W{1'b0}};
         r_pend <= 1'b0;
      end else begin
         if (w_load) begin
            r_coll <= {FW{1'b0}};
            r_fill <= {FILL_W{1'b0}};
         end else if (w_sample) begin
            r_coll <= w_coll_next;
            r_fill <= r_fill + FILL_W'(1);
         end else begin
            r_coll <= r_coll;
            r_fill <= r_fill;
         end
         if (w_flush_go) begin
            r_dec <= {DEC_W{1'b0}};
         end else if (w_beat) begin
            r_dec <= w_dec_hit ? {DEC_W{1'b0}} : r_dec + DEC_W'(1);
         end else begin
            r_dec <= r_dec;
         end
         r_pend <= w_flush_hold;
      end
   end

   // Holding register: loads when free, drains on out_ready.
   always_ff @(posedge clk or posedge in_ctr_Arst) begin
      if (in_ctr_Arst) begin
         r_out     <= {FW{1'b0}};
         r_valid   <= 1'b0;
         r_partial <= 1'b0;
      end else if (in_ctr_Srst) begin
         r_out     <= {FW{1'b0}};
         r_valid   <= 1'b0;
         r_partial <= 1'b0;
      end else if (w_load) begin
         r_out     <= w_coll_next;
         r_valid   <= 1'b1;
         r_partial <= w_flush_go;
      end else if (out_ready) begin
         r_valid   <= 1'b0;
      end else begin
         r_valid   <= r_valid;
      end
   end

endmodule

// File: tb/tb_seq_to_sim_frame_reg.sv
// Bench for seq_to_sim_frame_reg: a frame-level model checks the default instance every
// cycle; two extra instances cover lane ordering and decimation with literal expectations.
module tb_seq_to_sim_frame_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic arst, srst;

   logic        a_en, a_rdy, a_valid, a_ordy, a_part, a_flush;
   logic [1:0]  a_in;
   logic [15:0] a_out;

   logic        b_en, b_rdy, b_valid, b_part;
   logic [7:0]  b_in;
   logic [15:0] b_out;

   logic        c_en, c_rdy, c_valid, c_part;
   logic [3:0]  c_in;
   logic [7:0]  c_out;

   seq_to_sim_frame_reg dut_a (
      .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_en(a_en),
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
      .in_ctr_flush(a_flush),
`endif
      .in_ready(a_rdy), .in(a_in), .out(a_out), .out_valid(a_valid),
      .out_ready(a_ordy), .out_partial(a_part)
   );

   seq_to_sim_frame_reg #(.DIRECTION(0), .SHIFT_LEN(4), .BIT_WIDTH(4), .LANES(2)) dut_b (
      .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_en(b_en),
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
      .in_ctr_flush(1'b0),
`endif
      .in_ready(b_rdy), .in(b_in), .out(b_out), .out_valid(b_valid),
      .out_ready(1'b1), .out_partial(b_part)
   );

   seq_to_sim_frame_reg #(.SHIFT_LEN(2), .BIT_WIDTH(4), .CLK_DISTANCE(3)) dut_c (
      .clk(clk), .in_ctr_Arst(arst), .in_ctr_Srst(srst), .in_ctr_en(c_en),
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
      .in_ctr_flush(1'b0),
`endif
      .in_ready(c_rdy), .in(c_in), .out(c_out), .out_valid(c_valid),
      .out_ready(1'b1), .out_partial(c_part)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Frame-level model of dut_a: words queue, held frame, pending flush.
   logic [1:0]  m_words[$];
   logic        m_valid, m_part, m_pend;
   logic [15:0] m_out;
   logic        e_rdy, e_free, e_load, e_part;
   logic [15:0] e_frame;

   function automatic logic [15:0] build_frame();
      logic [15:0] f;
      f = 16'h0000;
      for (int p = 0; p < m_words.size(); p++) f[(7-p)*2 +: 2] = m_words[p];
      return f;
   endfunction

   always @(posedge clk) begin
      if (arst) begin
         m_words.delete();
         m_valid = 1'b0; m_part = 1'b0; m_pend = 1'b0; m_out = 16'h0000;
      end else begin
         e_free = !m_valid || a_ordy;
         e_rdy  = !((m_words.size() == 7) && m_valid && !a_ordy) && !m_pend;
         chk("in_ready", 32'(a_rdy), 32'(e_rdy));
         if (srst) begin
            m_words.delete();
            m_valid = 1'b0; m_part = 1'b0; m_pend = 1'b0; m_out = 16'h0000;
         end else begin
            e_load = 1'b0; e_part = 1'b0; e_frame = 16'h0000;
            if (a_en && e_rdy) m_words.push_back(a_in);
            if (m_words.size() == 8) begin
               e_frame = build_frame(); e_load = 1'b1; m_words.delete();
            end
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
            else if ((a_flush || m_pend) && m_words.size() > 0) begin
               if (e_free) begin
                  e_frame = build_frame(); e_load = 1'b1; e_part = 1'b1;
                  m_words.delete(); m_pend = 1'b0;
               end else begin
                  m_pend = 1'b1;
               end
            end else begin
               m_pend = 1'b0;
            end
`endif
            if (e_load) begin
               m_valid = 1'b1; m_out = e_frame; m_part = e_part;
            end else if (a_ordy) begin
               m_valid = 1'b0;
            end
         end
      end
      #1;
      chk("out_valid", 32'(a_valid), 32'(m_valid));
      chk("out_partial", 32'(a_part), 32'(m_part));
      chk("out", 32'(a_out), 32'(m_out));
   end

   logic [1:0] fb [8];

   initial begin
      fb = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
      arst = 1'b1; srst = 1'b0; a_flush = 1'b0;
      a_en = 1'b0; a_in = 2'd0; a_ordy = 1'b1;
      b_en = 1'b0; b_in = 8'h00; c_en = 1'b0; c_in = 4'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out", 32'(a_out), 32'h0);
      chk("rst_valid", 32'(a_valid), 32'h0);
      chk("rst_partial", 32'(a_part), 32'h0);
      chk("rst_b_valid", 32'(b_valid), 32'h0);
      arst = 1'b0;

      // Reverse direction, two lanes
      @(negedge clk); b_en = 1'b1; b_in = 8'h21;
      @(negedge clk); b_in = 8'h43;
      @(negedge clk); b_en = 1'b0; #1;
      chk("rev_out", 32'(b_out), 32'h4321);
      chk("rev_valid", 32'(b_valid), 32'h1);

      // Decimation by 3: beats 3 and 6 are sampled
      for (int v = 1; v <= 6; v++) begin
         @(negedge clk); #1;
         if (v == 6) chk("dec_early_valid", 32'(c_valid), 32'h0);
         c_en = 1'b1; c_in = 4'(v);
      end
      @(negedge clk); c_en = 1'b0; #1;
      chk("dec_out", 32'(c_out), 32'h36);
      chk("dec_valid", 32'(c_valid), 32'h1);

      // Basic frame
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i);
      end
      @(negedge clk); a_en = 1'b0; #1;
      chk("basic_valid", 32'(a_valid), 32'h1);
      chk("basic_out", 32'(a_out), 32'h1B1B);
      @(negedge clk); #1;
      chk("basic_drain", 32'(a_valid), 32'h0);

      // Backpressure: frame A then B with out_ready low
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); a_ordy = 1'b0; a_in = fb[i]; #1;
         chk("bp_rdy_mid", 32'(a_rdy), 32'h1);
      end
      @(negedge clk); a_in = fb[7]; #1;
      chk("bp_rdy_last", 32'(a_rdy), 32'h0);
      repeat (2) begin
         @(negedge clk); #1;
         chk("bp_hold_out", 32'(a_out), 32'h1B1B);
         chk("bp_hold_valid", 32'(a_valid), 32'h1);
      end
      @(negedge clk); a_ordy = 1'b1; #1;
      chk("bp_rdy_release", 32'(a_rdy), 32'h1);
      @(negedge clk); a_en = 1'b0; #1;
      chk("bp_b_out", 32'(a_out), 32'hFA50);
      chk("bp_b_valid", 32'(a_valid), 32'h1);

      // Asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i + 1);
      end
      @(negedge clk); a_en = 1'b0; #2; arst = 1'b1; #1;
      chk("arst_out", 32'(a_out), 32'h0);
      chk("arst_valid", 32'(a_valid), 32'h0);
      @(negedge clk); arst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(3 - (i % 4));
      end
      @(negedge clk); a_en = 1'b0; #1;
      chk("arst_next_out", 32'(a_out), 32'hE4E4);

      // Synchronous reset mid-frame, asserted together with a beat
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i);
      end
      @(negedge clk); a_in = 2'd3; srst = 1'b1;
      @(negedge clk); srst = 1'b0; a_en = 1'b0; #1;
      chk("srst_out", 32'(a_out), 32'h0);
      chk("srst_valid", 32'(a_valid), 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = (i < 4) ? 2'd1 : 2'd2;
      end
      @(negedge clk); a_en = 1'b0; #1;
      chk("srst_next_out", 32'(a_out), 32'h55AA);

`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
      @(negedge clk); a_flush = 1'b1;
      @(negedge clk); a_flush = 1'b0;
      @(negedge clk); #1;
      chk("flush_empty_valid", 32'(a_valid), 32'h0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i);
      end
      @(negedge clk); a_en = 1'b0; a_flush = 1'b1;
      @(negedge clk); a_flush = 1'b0; #1;
      chk("flush_out", 32'(a_out), 32'h6C00);
      chk("flush_partial", 32'(a_part), 32'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); a_en = 1'b1; a_in = 2'(i);
      end
      @(negedge clk); a_en = 1'b0; #1;
      chk("flush_full_out", 32'(a_out), 32'h1B1B);
      chk("flush_full_partial", 32'(a_part), 32'h0);
`endif

      // Mixed traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         a_en   = 1'($urandom_range(0, 3) != 0);
         a_in   = 2'($urandom_range(0, 3));
         a_ordy = 1'($urandom_range(0, 1));
`ifdef SEQ_TO_SIM_FRAME_FLUSH_EN
         a_flush = 1'($urandom_range(0, 7) == 0);
`endif
      end
      @(negedge clk); a_en = 1'b0; a_ordy = 1'b1; a_flush = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
